// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared register-file defaults and address-width helper
package regfile_mp_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_NREGS  = 32;
    localparam int RF_NUM_RD = 3;
    localparam int RF_NUM_WR = 2;

    function automatic int rf_addr_w(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - decode/writeback bundle of the multi-port register file
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int NREGS  = RF_NREGS,
    parameter int NUM_RD = RF_NUM_RD,
    parameter int NUM_WR = RF_NUM_WR
);
    localparam int AW = rf_addr_w(NREGS);

    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR-1:0]        wr_kill;
    logic [NUM_WR*AW-1:0]     wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     alloc_en;
    logic [AW-1:0]            alloc_addr;
    logic                     flush;
    logic [NREGS-1:0]         busy_vec;

    modport master (
        output rd_addr, wr_en, wr_kill, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_kill, wr_addr, wr_data, alloc_en, alloc_addr, flush,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one read port: zero/overflow check, write bypass, busy view
module regfile_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int NREGS  = RF_NREGS,
    parameter int NUM_WR = RF_NUM_WR,
    parameter int BYPASS = 1,
    parameter int AW     = rf_addr_w(RF_NREGS)
) (
    input  logic [AW-1:0]            i_addr,
    input  logic [DATA_W-1:0]        i_stored,
    input  logic                     i_busy,
    input  logic [NUM_WR-1:0]        i_wr_commit,
    input  logic [NUM_WR*AW-1:0]     i_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
    input  logic                     i_alloc_hit,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_busy
);
    logic              w_hit;
    logic [DATA_W-1:0] w_fwd;

    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        // Scan high to low so the lowest-index committing port is the one left standing
        for (int j = NUM_WR - 1; j >= 0; j--) begin
            if (i_wr_commit[j] && (i_wr_addr[j*AW +: AW] == i_addr)) begin
                w_hit = 1'b1;
                w_fwd = i_wr_data[j*DATA_W +: DATA_W];
            end
        end

        o_data = i_stored;
        o_busy = i_busy;
        if ((BYPASS != 0) && w_hit) begin
            o_data = w_fwd;
            if (!i_alloc_hit) o_busy = 1'b0;
        end
        if ((i_addr == '0) || (int'(i_addr) >= NREGS)) begin
            o_data = '0;
            o_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with pending-write scoreboard
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int NREGS  = RF_NREGS,
    parameter int NUM_RD = RF_NUM_RD,
    parameter int NUM_WR = RF_NUM_WR,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int AW = rf_addr_w(NREGS);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;

    logic [NUM_WR-1:0] w_commit;
    logic [AW-1:0]     w_waddr [NUM_WR];
    logic [DATA_W-1:0] w_wdata [NUM_WR];
    logic              w_alloc_ok;
    logic [NREGS-1:0]  w_busy_nxt;

    // Out-of-range addresses are folded into commit so they never touch storage or busy
    always_comb begin
        for (int j = 0; j < NUM_WR; j++) begin
            w_waddr[j]  = bus.wr_addr[j*AW +: AW];
            w_wdata[j]  = bus.wr_data[j*DATA_W +: DATA_W];
            w_commit[j] = bus.wr_en[j] && !bus.wr_kill[j] && (w_waddr[j] != '0)
                          && (int'(w_waddr[j]) < NREGS);
        end
    end

    assign w_alloc_ok = bus.alloc_en && (bus.alloc_addr != '0) && (int'(bus.alloc_addr) < NREGS);

    always_comb begin
        w_busy_nxt = r_busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (w_commit[j]) w_busy_nxt[w_waddr[j]] = 1'b0;
        end
        if (w_alloc_ok) w_busy_nxt[bus.alloc_addr] = 1'b1;
        if (bus.flush)  w_busy_nxt = '0;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
            r_busy <= '0;
        end else begin
            // Later assignments win, so walking down leaves port 0 with the last word
            for (int j = NUM_WR - 1; j >= 0; j--) begin
                if (w_commit[j]) r_regs[w_waddr[j]] <= w_wdata[j];
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign bus.busy_vec = r_busy;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]     w_raddr;
        logic [DATA_W-1:0] w_stored;
        logic              w_sbusy;
        logic              w_alloc_hit;
        logic [DATA_W-1:0] w_rdata;
        logic              w_rbusy;

        assign w_raddr     = bus.rd_addr[i*AW +: AW];
        assign w_stored    = (int'(w_raddr) < NREGS) ? r_regs[w_raddr] : '0;
        assign w_sbusy     = (int'(w_raddr) < NREGS) ? r_busy[w_raddr] : 1'b0;
        assign w_alloc_hit = w_alloc_ok && (bus.alloc_addr == w_raddr);

        regfile_rd_port #(
            .DATA_W (DATA_W),
            .NREGS  (NREGS),
            .NUM_WR (NUM_WR),
            .BYPASS (BYPASS),
            .AW     (AW)
        ) u_rd_port (
            .i_addr      (w_raddr),
            .i_stored    (w_stored),
            .i_busy      (w_sbusy),
            .i_wr_commit (w_commit),
            .i_wr_addr   (bus.wr_addr),
            .i_wr_data   (bus.wr_data),
            .i_alloc_hit (w_alloc_hit),
            .o_data      (w_rdata),
            .o_busy      (w_rbusy)
        );

        assign bus.rd_data[i*DATA_W +: DATA_W] = w_rdata;
        assign bus.rd_busy[i]                  = w_rbusy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench driving a bypass and a non-bypass register file in lockstep
module tb_regfile_mp;
    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 3;
    localparam int NWR = 2;
    localparam int AW  = 5;

    typedef struct {
        string       tag;
        int          kind;
        bit          byp;
        int          port;
        logic [31:0] exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    sb_t  sb[$];

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .NREGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) bus_b ();
    regfile_mp_if #(.DATA_W(DW), .NREGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) bus_n ();

    regfile_mp #(.DATA_W(DW), .NREGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1)) u_dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );
    regfile_mp #(.DATA_W(DW), .NREGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(0)) u_dut_n (
        .clk (clk), .rst (rst), .bus (bus_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        bus_b.rd_addr = '0;  bus_n.rd_addr = '0;
        bus_b.wr_en = '0;    bus_n.wr_en = '0;
        bus_b.wr_kill = '0;  bus_n.wr_kill = '0;
        bus_b.wr_addr = '0;  bus_n.wr_addr = '0;
        bus_b.wr_data = '0;  bus_n.wr_data = '0;
        bus_b.alloc_en = 0;  bus_n.alloc_en = 0;
        bus_b.alloc_addr = '0; bus_n.alloc_addr = '0;
        bus_b.flush = 0;     bus_n.flush = 0;
    endtask

    task automatic set_rd(input int p, input int a);
        bus_b.rd_addr[p*AW +: AW] = a[AW-1:0];
        bus_n.rd_addr[p*AW +: AW] = a[AW-1:0];
    endtask

    task automatic set_wr(input int j, input bit kill, input int a, input logic [31:0] d);
        bus_b.wr_en[j] = 1'b1;  bus_n.wr_en[j] = 1'b1;
        bus_b.wr_kill[j] = kill; bus_n.wr_kill[j] = kill;
        bus_b.wr_addr[j*AW +: AW] = a[AW-1:0];
        bus_n.wr_addr[j*AW +: AW] = a[AW-1:0];
        bus_b.wr_data[j*DW +: DW] = d;
        bus_n.wr_data[j*DW +: DW] = d;
    endtask

    task automatic set_alloc(input int a);
        bus_b.alloc_en = 1'b1; bus_n.alloc_en = 1'b1;
        bus_b.alloc_addr = a[AW-1:0]; bus_n.alloc_addr = a[AW-1:0];
    endtask

    task automatic set_flush();
        bus_b.flush = 1'b1; bus_n.flush = 1'b1;
    endtask

    task automatic exp_rd(input string tag, input bit byp, input int p, input logic [31:0] v);
        sb.push_back('{tag, 0, byp, p, v});
    endtask

    task automatic exp_both(input string tag, input int p, input logic [31:0] v);
        exp_rd({tag, "_byp"}, 1'b1, p, v);
        exp_rd({tag, "_nob"}, 1'b0, p, v);
    endtask

    task automatic exp_busy(input string tag, input bit byp, input int p, input bit v);
        sb.push_back('{tag, 1, byp, p, {31'b0, v}});
    endtask

    task automatic exp_vec(input string tag, input logic [31:0] v);
        sb.push_back('{{tag, "_byp"}, 2, 1'b1, 0, v});
        sb.push_back('{{tag, "_nob"}, 2, 1'b0, 0, v});
    endtask

    task automatic sample_cycle();
        sb_t         e;
        logic [31:0] obs;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       obs = e.byp ? bus_b.rd_data[e.port*DW +: DW] : bus_n.rd_data[e.port*DW +: DW];
                1:       obs = {31'b0, (e.byp ? bus_b.rd_busy[e.port] : bus_n.rd_busy[e.port])};
                default: obs = e.byp ? bus_b.busy_vec : bus_n.busy_vec;
            endcase
            check(e.tag, obs, e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int a = 0; a < NR; a += NRD) begin
            idle();
            for (int p = 0; p < NRD; p++) begin
                int ad;
                ad = (a + p < NR) ? a + p : 0;
                set_rd(p, ad);
                exp_both($sformatf("rst_rd_x%0d", ad), p, 32'h0);
                exp_busy($sformatf("rst_busy_x%0d", ad), 1'b1, p, 1'b0);
            end
            exp_vec("rst_vec", 32'h0);
            sample_cycle();
        end

        idle();
        set_wr(0, 0, 5, 32'hAAAA_0000);
        set_wr(1, 0, 5, 32'h5555_FFFF);
        set_rd(0, 5);
        exp_rd("coll_same_byp", 1'b1, 0, 32'hAAAA_0000);
        exp_rd("coll_same_nob", 1'b0, 0, 32'h0);
        sample_cycle();
        idle();
        set_rd(0, 5);
        exp_both("coll_next", 0, 32'hAAAA_0000);
        set_wr(0, 0, 6, 32'h0000_0066);
        set_wr(1, 0, 8, 32'h0000_0088);
        sample_cycle();
        idle();
        set_rd(1, 6);
        set_rd(2, 8);
        exp_both("dual_x6", 1, 32'h0000_0066);
        exp_both("dual_x8", 2, 32'h0000_0088);
        sample_cycle();

        idle();
        set_wr(0, 0, 0, 32'hDEAD_BEEF);
        set_rd(0, 0);
        exp_both("x0_same", 0, 32'h0);
        sample_cycle();
        idle();
        set_rd(0, 0);
        exp_both("x0_next", 0, 32'h0);
        exp_vec("x0_vec", 32'h0);
        sample_cycle();

        idle();
        set_wr(0, 0, 3, 32'h0000_0033);
        sample_cycle();
        idle();
        set_alloc(3);
        sample_cycle();
        idle();
        set_wr(0, 1, 3, 32'h0000_0007);
        set_rd(0, 3);
        exp_both("kill_same", 0, 32'h0000_0033);
        exp_busy("kill_busy_byp", 1'b1, 0, 1'b1);
        exp_busy("kill_busy_nob", 1'b0, 0, 1'b1);
        sample_cycle();
        idle();
        set_rd(0, 3);
        exp_both("kill_next", 0, 32'h0000_0033);
        exp_vec("kill_vec", 32'h0000_0008);
        set_flush();
        sample_cycle();
        idle();
        exp_vec("kill_flush_vec", 32'h0);
        sample_cycle();

        idle();
        set_wr(0, 0, 9, 32'h0000_1234);
        set_rd(1, 9);
        exp_rd("x9_same_byp", 1'b1, 1, 32'h0000_1234);
        exp_rd("x9_same_nob", 1'b0, 1, 32'h0);
        sample_cycle();
        idle();
        set_rd(1, 9);
        exp_both("x9_next", 1, 32'h0000_1234);
        sample_cycle();

        idle();
        set_alloc(7);
        exp_vec("alloc7_before", 32'h0);
        sample_cycle();
        idle();
        set_alloc(7);
        set_wr(0, 0, 7, 32'h0000_0077);
        set_rd(0, 7);
        exp_vec("alloc7_vec", 32'h0000_0080);
        exp_busy("alloc7_wr_busy_byp", 1'b1, 0, 1'b1);
        exp_busy("alloc7_wr_busy_nob", 1'b0, 0, 1'b1);
        sample_cycle();
        idle();
        set_wr(1, 0, 7, 32'h0000_0078);
        set_rd(0, 7);
        exp_vec("alloc7_hold_vec", 32'h0000_0080);
        exp_busy("wb7_busy_byp", 1'b1, 0, 1'b0);
        exp_busy("wb7_busy_nob", 1'b0, 0, 1'b1);
        exp_rd("wb7_data_byp", 1'b1, 0, 32'h0000_0078);
        exp_rd("wb7_data_nob", 1'b0, 0, 32'h0000_0077);
        sample_cycle();
        idle();
        set_rd(0, 7);
        exp_vec("wb7_vec", 32'h0);
        exp_both("wb7_next", 0, 32'h0000_0078);
        exp_busy("wb7_next_busy_nob", 1'b0, 0, 1'b0);
        sample_cycle();

        idle();
        set_alloc(2);
        sample_cycle();
        idle();
        set_alloc(4);
        exp_vec("alloc2_vec", 32'h0000_0004);
        sample_cycle();
        idle();
        set_flush();
        set_alloc(6);
        exp_vec("alloc24_vec", 32'h0000_0014);
        sample_cycle();
        idle();
        set_alloc(0);
        exp_vec("flush_vec", 32'h0);
        sample_cycle();
        idle();
        exp_vec("alloc0_vec", 32'h0);
        sample_cycle();

        idle();
        rst = 1'b1;
        set_wr(0, 0, 10, 32'h0000_00FF);
        set_alloc(10);
        sample_cycle();
        rst = 1'b0;
        idle();
        set_rd(0, 10);
        set_rd(1, 5);
        set_rd(2, 9);
        exp_both("rstw_x10", 0, 32'h0);
        exp_both("rstw_x5", 1, 32'h0);
        exp_both("rstw_x9", 2, 32'h0);
        exp_busy("rstw_busy_byp", 1'b1, 0, 1'b0);
        exp_vec("rstw_vec", 32'h0);
        sample_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
